// File: rtl/button_pkg.sv
// Shared definitions for the input-conditioning blocks.
// Holds the debouncer FSM state encodings and the default timing constants
// (cycle counts assume a fast system clock; benches override them).
package button_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        HELD         = ST_HELD,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; clears both flop stages
//   d     - asynchronous input
//   q     - synchronized output (two clock latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync0;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0 <= '0;
            q     <= '0;
        end else begin
            sync0 <= d;
            q     <= sync0;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw button, debounces both edges
// and produces a one-cycle press pulse plus a debounced level. While held
// with repeatEnable set, extra pulses follow after REPEAT_DELAY cycles and
// then every REPEAT_PERIOD cycles.
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high
//   button       - raw asynchronous button input
//   repeatEnable - level, enables auto-repeat while held
//   buttonPulse  - registered one-cycle pulse per press / repeat event
//   buttonLevel  - registered debounced button state
//
// state        | meaning
// -------------+----------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | synced input high, counting stable high cycles
// HELD         | press accepted; auto-repeat timing runs here
// RELEASE_WAIT | synced input low, counting stable low cycles
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = button_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = button_pkg::DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = button_pkg::DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic repeatEnable,
    output logic buttonPulse,
    output logic buttonLevel
);

    import button_pkg::*;

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_W   = $clog2(REP_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic             s;
    btn_state_t       state;
    logic [DB_W-1:0]  db_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             rep_phase;
    logic [REP_W-1:0] rep_last;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (s)
    );

    // First repeat waits the long delay, later ones use the period.
    assign rep_last = rep_phase ? PERIOD_LAST : DELAY_LAST;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            db_cnt      <= '0;
            rep_cnt     <= '0;
            rep_phase   <= 1'b0;
            buttonPulse <= 1'b0;
            buttonLevel <= 1'b0;
        end else begin
            buttonPulse <= 1'b0;
            case (state)
                IDLE: begin
                    buttonLevel <= 1'b0;
                    if (s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        buttonPulse <= 1'b1;
                        buttonLevel <= 1'b1;
                        rep_cnt     <= '0;
                        rep_phase   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end else if (!repeatEnable) begin
                        rep_cnt   <= '0;
                        rep_phase <= 1'b0;
                    end else if (rep_cnt == rep_last) begin
                        buttonPulse <= 1'b1;
                        rep_cnt     <= '0;
                        rep_phase   <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    // A short low glitch returns to HELD without a new press pulse.
                    if (s) begin
                        state     <= HELD;
                        rep_cnt   <= '0;
                        rep_phase <= 1'b0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= IDLE;
                        buttonLevel <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    import button_pkg::*;

    logic clock;
    logic reset;
    logic button;
    logic repeatEnable;
    logic buttonPulse;
    logic buttonLevel;

    int n_total = 0;
    int n_bad   = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button       (button),
        .repeatEnable (repeatEnable),
        .buttonPulse  (buttonPulse),
        .buttonLevel  (buttonLevel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Advance past the next rising edge; sampling and driving happen 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_to_idle();
        button = 1'b0;
        repeat (10) tick();
        chk("idle_level", buttonLevel, 1'b0);
        chk("idle_state", dut.state, ST_IDLE);
    endtask

    initial begin
        int e;
        logic exp_p;
        reset        = 1'b1;
        button       = 1'b0;
        repeatEnable = 1'b0;
        repeat (3) tick();
        chk("rst_pulse", buttonPulse, 1'b0);
        chk("rst_level", buttonLevel, 1'b0);
        chk("rst_state", dut.state, ST_IDLE);
        reset = 1'b0;
        repeat (3) tick();

        // Clean press, no repeat: pulse only after edge t0+6.
        button = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            chk("press_pulse", buttonPulse, (k == 6));
            chk("press_level", buttonLevel, (k >= 6));
        end

        // Release from held: level drops after edge t0+6.
        button = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            tick();
            chk("rel_level", buttonLevel, (k < 6));
            chk("rel_pulse", buttonPulse, 1'b0);
        end

        // Bounce: high runs of 1, 2, 3 separated by 2-cycle lows.
        begin
            logic [15:0] pat;
            pat = 16'b0000_0111_0011_0010;
            for (int k = 0; k < 24; k++) begin
                button = (k < 16) ? pat[k] : 1'b0;
                tick();
                chk("bounce_pulse", buttonPulse, 1'b0);
                chk("bounce_level", buttonLevel, 1'b0);
            end
        end

        // Press, then a 2-cycle release glitch: level stays high, no pulse.
        button = 1'b1;
        for (int k = 0; k <= 8; k++) tick();
        chk("glitch_pre_level", buttonLevel, 1'b1);
        button = 1'b0;
        tick();
        tick();
        button = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("glitch_level", buttonLevel, 1'b1);
            chk("glitch_pulse", buttonPulse, 1'b0);
        end
        release_to_idle();

        // Auto-repeat held: E, E+10, E+13, ..., E+28 where E = t0+6.
        repeatEnable = 1'b1;
        button       = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            tick();
            e = k - 6;
            exp_p = (e == 0) || (e >= 10 && ((e - 10) % 3) == 0);
            chk("rep_pulse", buttonPulse, exp_p);
            chk("rep_level", buttonLevel, (e >= 0));
        end
        release_to_idle();

        // Drop repeatEnable at E+14, re-assert at E+21: next pulse at E+30.
        repeatEnable = 1'b1;
        button       = 1'b1;
        for (int k = 0; k <= 38; k++) begin
            tick();
            e = k - 6;
            exp_p = (e == 0) || (e == 10) || (e == 13) || (e == 30);
            chk("repen_pulse", buttonPulse, exp_p);
            if (e == 13) repeatEnable = 1'b0;
            if (e == 20) repeatEnable = 1'b1;
        end
        repeatEnable = 1'b0;
        release_to_idle();

        // Reset mid-press at edge t0+4: next pulse after edge t0+11.
        button = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 4) begin
                chk("midrst_pulse", buttonPulse, 1'b0);
                chk("midrst_level", buttonLevel, 1'b0);
                chk("midrst_state", dut.state, ST_IDLE);
                reset = 1'b0;
            end else begin
                chk("midrst_p", buttonPulse, (k == 11));
                chk("midrst_l", buttonLevel, (k >= 11));
            end
            if (k == 3) reset = 1'b1;
        end
        release_to_idle();

        // Reset coincident with the PRESS_WAIT -> HELD edge (t0+6).
        button = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 6) begin
                chk("simul_pulse", buttonPulse, 1'b0);
                chk("simul_level", buttonLevel, 1'b0);
                chk("simul_state", dut.state, ST_IDLE);
                reset = 1'b0;
            end else if (k == 7) begin
                chk("simul_state_after", dut.state, ST_IDLE);
            end else if (k > 7) begin
                chk("simul_repress", buttonPulse, (k == 13));
            end else begin
                chk("simul_pre", buttonPulse, 1'b0);
            end
            if (k == 5) reset = 1'b1;
        end
        release_to_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
